// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a per-register pending-write scoreboard.
// Optional REGARB_ZERO_DROP_EN: writes and reservations targeting register 0 are dropped.
module regfile_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_addr,
    input  logic [ADDR_W-1:0]      chk_rs,
    input  logic [ADDR_W-1:0]      chk_rt,
    output logic                   hazard_rs,
    output logic                   hazard_rt,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [31:0]            pending
);
    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  grantIdx;
    logic [PTR_W-1:0]  candIdx;
    logic              anyGrant;
    logic [ADDR_W-1:0] addrArr [NREQ];
    logic [DATA_W-1:0] dataArr [NREQ];
    logic [ADDR_W-1:0] grantAddr;
    logic [DATA_W-1:0] grantData;
    logic              writeKeep;
    logic              rsvKeep;
    logic [31:0]       pendingNext;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addrArr[i] = req_addr[i*ADDR_W +: ADDR_W];
            dataArr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan from ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        anyGrant = 1'b0;
        grantIdx = '0;
        candIdx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            candIdx = PTR_W'((32'(ptr) + k) % NREQ);
            if (!anyGrant && req_valid[candIdx]) begin
                anyGrant = 1'b1;
                grantIdx = candIdx;
            end
        end
        req_ready = '0;
        if (anyGrant && rst_n) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    always_comb begin
        grantAddr = addrArr[grantIdx];
        grantData = dataArr[grantIdx];
`ifdef REGARB_ZERO_DROP_EN
        writeKeep = anyGrant && (grantAddr != '0);
        rsvKeep   = rsv_valid && (rsv_addr != '0);
`else
        writeKeep = anyGrant;
        rsvKeep   = rsv_valid;
`endif
    end

    // Set is applied after clear so a same-edge reservation keeps the register pending.
    always_comb begin
        pendingNext = pending;
        if (rf_we) begin
            pendingNext[rf_waddr] = 1'b0;
        end
        if (rsvKeep) begin
            pendingNext[rsv_addr] = 1'b1;
        end
`ifdef REGARB_ZERO_DROP_EN
        pendingNext[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            pending  <= '0;
        end else begin
            if (anyGrant) begin
                ptr <= (grantIdx == PTR_W'(NREQ - 1)) ? '0 : grantIdx + PTR_W'(1);
            end
            rf_we <= writeKeep;
            if (writeKeep) begin
                rf_waddr <= grantAddr;
                rf_wdata <= grantData;
            end
            pending <= pendingNext;
        end
    end

    assign hazard_rs = pending[chk_rs];
    assign hazard_rt = pending[chk_rt];

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×32 register file among several result producers (ALU, load unit, multiply/divide unit) using round-robin arbitration with valid/ready handshakes. It also keeps a per-register pending-write scoreboard so decode can detect read-after-write hazards on rs/rt. It sits between the execution units and the register file write port (`WriteEnable`, destination, `WriteData`).

## Interface
Parameters:
- `NREQ`, 3: number of write requesters (2..8).
- `DATA_W`, 32: write data width.
- `ADDR_W`, 5: register address width (32 registers).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `req_valid`  in  NREQ: requester i holds a write.
- `req_ready`  out  NREQ: grant to requester i (one-hot or zero).
- `req_addr`  in  NREQ*ADDR_W: destination register of requester i, in bits [i*ADDR_W +: ADDR_W].
- `req_data`  in  NREQ*DATA_W: write data of requester i, in bits [i*DATA_W +: DATA_W].
- `rsv_valid`  in  1: issue is reserving a destination.
- `rsv_addr`  in  ADDR_W: register being reserved.
- `chk_rs`, `chk_rt`  in  ADDR_W each: source registers under decode.
- `hazard_rs`, `hazard_rt`  out  1 each: the checked register has a pending write.
- `rf_we`  out  1: register file write enable.
- `rf_waddr`  out  ADDR_W: register file write address.
- `rf_wdata`  out  DATA_W: register file write data.
- `pending`  out  32: scoreboard vector.

## Operation
- Arbitration is combinational. Candidates are scanned from `ptr` upward, wrapping modulo NREQ. The first i with `req_valid[i]`=1 wins and gets `req_ready[i]`=1. All other ready bits are 0.
- A transfer occurs when `req_valid[i]` and `req_ready[i]` are both high at a rising edge.
- `ptr` (width clog2(NREQ)) becomes (g+1) mod NREQ after a grant to g. It is unchanged when there is no grant.
- The write port is never back-pressured, so one requester is granted in every cycle in which any requester is valid.
- Output register: on a transfer, `rf_we`←1, `rf_waddr`←`req_addr[g]`, `rf_wdata`←`req_data[g]`. With no transfer, `rf_we`←0 and address/data hold their values.
- Requesters keep address and data stable while valid and not ready.
- Scoreboard:
  - At an edge where `rsv_valid`=1: `pending[rsv_addr]`←1.
  - At an edge where `rf_we`=1: `pending[rf_waddr]`←0. This is the same edge at which the register file commits the write.
  - Set and clear of the same register at the same edge: set wins, because a newer instruction owns the register.
  - `hazard_rs`=`pending[chk_rs]` and `hazard_rt`=`pending[chk_rt]`, both combinational.
- Reset (asynchronous, while `rst_n`=0):
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `pending`=0, `ptr`=0.
  - `req_ready`=0 regardless of `req_valid`.
- Reset mid-operation discards any grant in progress and clears all reservations. No write is issued until a new transfer completes after `rst_n` rises.

## Timing
- Request-to-ready: 0 cycles (combinational from `req_valid` and `ptr`).
- Grant-to-write: 1 cycle. A transfer at edge N drives `rf_we`=1 during cycle N→N+1, and the register file commits at edge N+1.
- Hazard clear: `hazard_*` falls in the cycle after edge N+1. The register file read of the new data is valid in that same cycle.
- Throughput: one write per cycle sustained. Under continuous contention each requester receives one grant every NREQ cycles.
- Reservation visibility: the `hazard_*` rise is seen in the cycle after the `rsv_valid` edge.

## Configuration
- `REGARB_ZERO_DROP_EN` defined:
  - A transfer with address 0 is still accepted (ready asserted, `ptr` advances), but `rf_we` stays 0 for it.
  - `rsv_valid` with `rsv_addr`=0 is ignored.
  - `pending[0]` and `hazard_*` for register 0 are always 0.
- `REGARB_ZERO_DROP_EN` undefined: register 0 is treated like any other register. Writes reach the file and reservations are tracked.

## Test plan
- Single write: after reset, `req_valid`=3'b010, addr 5, data 0xDEADBEEF → `req_ready`=3'b010 in the same cycle; next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF; the cycle after, `rf_we`=0.
- Fairness: all three requesters valid continuously from reset → grant order 0,1,2,0,1,2; `rf_we` high every cycle.
- Hazard lifecycle: `rsv_valid` with addr 7, then `chk_rs`=7 → `hazard_rs`=1 from the next cycle; requester 0 writes 7 → `hazard_rs` returns to 0 in the cycle after `rf_we`=1 with `rf_waddr`=7.
- Set/clear collision: `rsv_valid` with addr 9 at the same edge as `rf_we`=1 with `rf_waddr`=9 → `pending[9]` remains 1.
- Zero register: write to addr 0 with data 0x1234 → with `REGARB_ZERO_DROP_EN`, ready=1 but `rf_we` stays 0; without it, `rf_we`=1 and `rf_waddr`=0.
- Reset mid-stream: drop `rst_n` during continuous grants with `pending`=0x00000280 → `rf_we`=0 and `pending`=0 immediately, without waiting for `clk`; after release, the first grant goes to requester 0.
